// File: rtl/seg7_scan_controller_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_controller_if
//   Bundles the shadow-write bus, commit/mask controls and the multiplexed
//   display drive of seg7_scan_controller.
//
//   Signals (direction seen from the slave, i.e. the controller):
//     wr_en          in   write one shadow digit this cycle
//     wr_digit       in   shadow index written
//     wr_seg         in   active-low segment pattern {g..a}
//     wr_dp          in   active-low decimal point
//     commit         in   request to copy shadow bank to active bank
//     digit_mask     in   1 = digit is scanned
//     seg            out  active-low segments
//     dp             out  active-low decimal point
//     an             out  active-low anodes
//     frame_done     out  one-cycle pulse at each frame boundary
//     commit_pending out  a commit is accepted and not yet applied
//
//   N_DIGITS must match the controller instance it is connected to.
// ---------------------------------------------------------------------------
interface seg7_scan_controller_if #(
  parameter int N_DIGITS = 8
) ();
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic                wr_en;
  logic [IDX_W-1:0]    wr_digit;
  logic [6:0]          wr_seg;
  logic                wr_dp;
  logic                commit;
  logic [N_DIGITS-1:0] digit_mask;
  logic [6:0]          seg;
  logic                dp;
  logic [N_DIGITS-1:0] an;
  logic                frame_done;
  logic                commit_pending;

  modport master (
    output wr_en, wr_digit, wr_seg, wr_dp, commit, digit_mask,
    input  seg, dp, an, frame_done, commit_pending
  );

  modport slave (
    input  wr_en, wr_digit, wr_seg, wr_dp, commit, digit_mask,
    output seg, dp, an, frame_done, commit_pending
  );
endinterface

// File: rtl/seg7_scan_controller.sv
// ---------------------------------------------------------------------------
// seg7_scan_controller
//   Time-multiplexed driver for an N_DIGITS seven-segment display with a
//   double-buffered digit store. Software writes the shadow bank at will and
//   requests a commit; the whole shadow bank is copied to the active bank at
//   the next frame boundary so a frame never shows a mix of old and new data.
//   Each digit slot starts with BLANK_TICKS cycles of all-off (anti-ghosting)
//   followed by the digit itself for the rest of TICKS_PER_DIGIT cycles.
//
//   Ports:
//     clk    single clock
//     reset  synchronous, active-high reset
//     bus    seg7_scan_controller_if.slave (write bus, commit, mask, drive)
//
//   All display outputs are registered: they reflect FSM state, slot counter
//   and current digit of the previous cycle.
// ---------------------------------------------------------------------------
module seg7_scan_controller #(
  parameter int N_DIGITS        = 8,
  parameter int TICKS_PER_DIGIT = 12500,
  parameter int BLANK_TICKS     = 100
) (
  input  logic                   clk,
  input  logic                   reset,
  seg7_scan_controller_if.slave  bus
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = $clog2(TICKS_PER_DIGIT);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_TICKS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_ON    = 2'd2;

  // Bank entries are {seg[6:0], dp}; 8'hFF is a fully dark digit.
  localparam logic [7:0] DARK = 8'hFF;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic                pend_q, pend_d;

  logic [7:0]          shadow_q [N_DIGITS];
  logic [7:0]          active_q [N_DIGITS];

  logic [6:0]          seg_q;
  logic                dp_q;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                frame_done_q;

  logic [N_DIGITS-1:0] wr_hit;
  logic [IDX_W-1:0]    lo_idx, up_idx, next_idx;
  logic                up_found;
  logic                mask_any, slot_end, boundary, apply;

  // -------------------------------------------------------------------------
  // Per-digit write decode and anode decode. An out-of-range wr_digit
  // matches no digit and is therefore dropped.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    assign wr_hit[gi] = bus.wr_en && (bus.wr_digit == IDX_W'(gi));
    assign an_d[gi]   = ~((state_q == ST_ON) && (cur_q == IDX_W'(gi)));
  end

  // -------------------------------------------------------------------------
  // Next digit search: lowest set mask bit above cur_q, else lowest set bit
  // overall. Scanning downwards lets the last hit be the lowest one.
  // -------------------------------------------------------------------------
  always_comb begin
    lo_idx   = '0;
    up_idx   = '0;
    up_found = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (bus.digit_mask[i]) begin
        lo_idx = IDX_W'(i);
        if (IDX_W'(i) > cur_q) begin
          up_idx   = IDX_W'(i);
          up_found = 1'b1;
        end
      end
    end
  end

  assign next_idx = up_found ? up_idx : lo_idx;
  assign mask_any = |bus.digit_mask;
  assign slot_end = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);

  // A frame ends when the scan wraps (next digit not above the current
  // one). Dropping into IDLE keeps cur, so that also closes the frame.
  assign boundary = slot_end && (!mask_any || (next_idx <= cur_q));

  // The copy only honours commits that were already pending, so a commit
  // landing on a boundary waits for the following one.
  assign apply  = pend_q && (boundary || (state_q == ST_IDLE));
  assign pend_d = bus.commit || (pend_q && !apply);

  // -------------------------------------------------------------------------
  // Scan FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      if (mask_any) begin
        state_d = ST_BLANK;
        cur_d   = lo_idx;
      end
    end else if (slot_end) begin
      cnt_d = '0;
      if (!mask_any) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_BLANK;
        cur_d   = next_idx;
      end
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = (cnt_d >= CNT_BLANK) ? ST_ON : ST_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      cur_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
    end
  end

  // -------------------------------------------------------------------------
  // Digit banks. The copy reads the pre-edge shadow contents, so a write in
  // the copy cycle lands in shadow only.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        shadow_q[i] <= DARK;
        active_q[i] <= DARK;
      end
    end else begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (apply) begin
          active_q[i] <= shadow_q[i];
        end
        if (wr_hit[i]) begin
          shadow_q[i] <= {bus.wr_seg, bus.wr_dp};
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registered display drive
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      an_q         <= an_d;
      frame_done_q <= boundary;
      if (state_q == ST_ON) begin
        seg_q <= active_q[cur_q][7:1];
        dp_q  <= active_q[cur_q][0];
      end else begin
        seg_q <= 7'h7F;
        dp_q  <= 1'b1;
      end
    end
  end

  assign bus.an             = an_q;
  assign bus.seg            = seg_q;
  assign bus.dp             = dp_q;
  assign bus.frame_done     = frame_done_q;
  assign bus.commit_pending = pend_q;

endmodule

// File: doc/seg7_scan_controller.md
SEG7_SCAN_CONTROLLER -- requirements
Module: seg7_scan_controller

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8: number of multiplexed digits.
REQ-002 SHALL have parameter TICKS_PER_DIGIT, default 12500: clk cycles per digit slot.
REQ-003 SHALL have parameter BLANK_TICKS, default 100: anti-ghosting blank cycles at the start of each slot; legal range 1 to TICKS_PER_DIGIT-1.
REQ-004 SHALL have port clk, input, 1: single clock.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port wr_en, input, 1: write one shadow digit this cycle.
REQ-007 SHALL have port wr_digit, input, $clog2(N_DIGITS): shadow index written.
REQ-008 SHALL have port wr_seg, input, 7: active-low segment pattern {g..a}.
REQ-009 SHALL have port wr_dp, input, 1: active-low decimal point.
REQ-010 SHALL have port commit, input, 1: one-cycle request to copy the shadow bank to the active bank.
REQ-011 SHALL have port digit_mask, input, N_DIGITS: 1 means the digit is scanned.
REQ-012 SHALL have port seg, output, 7: active-low segments.
REQ-013 SHALL have port dp, output, 1: active-low decimal point.
REQ-014 SHALL have port an, output, N_DIGITS: active-low anodes.
REQ-015 SHALL have port frame_done, output, 1: one-cycle pulse at each frame boundary.
REQ-016 SHALL have port commit_pending, output, 1: a commit is accepted and not yet applied.

Function
REQ-017 SHALL keep two banks (shadow, active) of N_DIGITS x {seg[6:0], dp}; wr_en writes shadow[wr_digit] at the clock edge; an out-of-range wr_digit is ignored.
REQ-018 SHALL run a slot counter cnt, 0..TICKS_PER_DIGIT-1, wrapping to 0; reaching TICKS_PER_DIGIT-1 is the slot end.
REQ-019 SHALL have FSM states IDLE, BLANK and ON; BLANK holds while cnt < BLANK_TICKS, ON holds while cnt >= BLANK_TICKS.
REQ-020 SHALL drive an all ones, seg 7'h7F and dp 1 in IDLE and BLANK; in ON, SHALL drive an[cur]=0 with all other bits 1, seg=active[cur].seg and dp=active[cur].dp.
REQ-021 SHALL register all outputs, so each output reflects FSM, cnt and cur from the previous cycle (one cycle latency).
REQ-022 SHALL sample digit_mask only at slot end; cur then advances to the next set mask bit above cur, wrapping to the lowest set bit.
REQ-023 SHALL let a mask change mid-slot take effect only at slot end; a currently displayed digit that becomes disabled completes its slot.
REQ-024 SHALL enter IDLE at slot end when digit_mask==0; in IDLE, cnt=0 and cur holds; when the mask becomes nonzero, SHALL go next cycle to BLANK with cur set to the lowest set bit and cnt=0.
REQ-025 SHALL define a frame boundary as a slot end where the next cur <= current cur, so a single enabled digit gives a boundary every slot; SHALL assert frame_done for exactly that cycle (registered).
REQ-026 SHALL set commit_pending on commit; at the next frame boundary, or on the next cycle while in IDLE, SHALL copy the whole shadow bank to active and clear commit_pending.
REQ-027 SHALL register a commit arriving in the same cycle as a frame boundary as pending and apply it at the following boundary.
REQ-028 SHALL NOT include a shadow write in the same cycle as a copy in that copy.
REQ-029 SHALL treat repeated commits while pending as a single commit.

Reset
REQ-030 SHALL, on reset, set cnt=0, state BLANK, cur=0 and both banks to {7'h7F,1}, clear commit_pending, and drive an=all ones, seg=7'h7F, dp=1 and frame_done=0 on the next cycle.
REQ-031 SHALL apply reset mid-slot or mid-commit immediately; the pending commit is discarded.

Verification (TICKS_PER_DIGIT=8, BLANK_TICKS=2, N_DIGITS=8)
REQ-032 SHALL cover: reset, mask=8'h01 -> an=FF for 2 cycles, then FE for 6 cycles, repeating; frame_done pulses every 8 cycles.
REQ-033 SHALL cover: mask=8'h05, shadow[0]=7'h40, shadow[2]=7'h79, commit -> after the next frame_done, an alternates FE with seg 40 and FB with seg 79 in 8-cycle slots; frame_done every 16 cycles.
REQ-034 SHALL cover: commit, then shadow[0]=7'h24 written before the boundary -> seg stays at the old value until frame_done, then shows 24; commit_pending drops the same cycle.
REQ-035 SHALL cover: mask switched 8'h05->8'h02 mid-slot of digit 0 -> digit 0 finishes its slot, then only an=FD is shown.
REQ-036 SHALL cover: mask=0 -> IDLE, an=FF; commit then completes in 1 cycle; mask=8'h80 -> BLANK, then an=7F.
REQ-037 SHALL cover: commit asserted on the frame_done cycle -> commit_pending stays 1 until the next frame_done.
